vpu_issue_sequencer: RTL and testbench
======================================

VPU_ISSUE_SEQUENCER -- requirements
Module: vpu_issue_sequencer

Interface
REQ-001 SHALL have parameter QUEUE_DEPTH, default 4, power-of-two command queue depth (2..16).
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 255, maximum cycles to wait for op_done (1..65535).
REQ-003 SHALL have one clock and a synchronous, active-high reset, with ports clk and rst.
REQ-004 SHALL have ports: clk in 1, rising-edge clock; rst in 1, synchronous active-high reset.
REQ-005 SHALL have ports: in_valid in 1, command offered; in_ready out 1, queue can accept; in_funct in 7, in_vs1 in 5, in_vs2 in 5, in_vr in 5, in_vl in 32, command fields.
REQ-006 SHALL have ports: vpu_enable out 1; vpu_start_op out 1; vpu_funct out 7; vpu_vs1/vpu_vs2/vpu_vr out 5 each; vpu_vl out 32; vpu_op_done in 1.
REQ-007 SHALL have ports: flush in 1, discard queued commands; busy out 1, queue non-empty or op in flight; queue_count out $clog2(QUEUE_DEPTH)+1; retire_cnt out 16, retired-command counter; err_timeout out 1, sticky timeout flag.

Function
REQ-008 SHALL accept a command on a cycle with in_valid && in_ready and push it into an in-order FIFO.
REQ-009 SHALL drive in_ready = !full && !flush; a push on a full cycle SHALL NOT occur, with no bypass around a full queue.
REQ-010 SHALL use an FSM with states IDLE, ISSUE and WAIT.
REQ-011 SHALL transition IDLE->ISSUE when the queue is non-empty and the head has vl!=0.
REQ-012 SHALL transition ISSUE->WAIT unconditionally after one cycle.
REQ-013 SHALL transition WAIT->IDLE on vpu_op_done, popping the head entry.
REQ-014 SHALL pulse vpu_start_op high for exactly one cycle, in the ISSUE state only.
REQ-015 SHALL register the vpu_funct/vs1/vs2/vr/vl outputs from the head entry on entry to ISSUE and hold them stable through WAIT.
REQ-016 SHALL hold vpu_enable high from ISSUE through WAIT.
REQ-017 SHALL achieve these latencies: a push into an empty IDLE queue at cycle N gives vpu_start_op at N+2; vpu_op_done at cycle M with a non-empty queue gives the next vpu_start_op at M+2.
REQ-018 SHALL pop a head entry with vl==0 in IDLE in one cycle without issuing it and SHALL still increment retire_cnt.
REQ-019 SHALL increment retire_cnt by 1 per pop (op_done or vl==0 skip), wrapping from 0xFFFF to 0.
REQ-020 SHALL ignore vpu_op_done in IDLE and ISSUE.
REQ-021 SHALL, on flush, empty the queue on the next edge, excluding an entry in ISSUE or WAIT, which completes normally.
REQ-022 SHALL give flush priority over push; a simultaneous push is dropped (in_ready is low).
REQ-023 SHALL give a simultaneous push and pop a net count change of 0.
REQ-024 SHALL keep queue_count equal to the exact occupancy, including any in-flight entry.

Reset
REQ-025 SHALL, on rst, return the FSM to IDLE, empty the queue, and clear vpu_start_op, vpu_enable, busy, queue_count, retire_cnt and err_timeout to 0.
REQ-026 SHALL, on rst, clear the vpu_* field outputs to 0 and set in_ready to 1 on the cycle after reset.
REQ-027 SHALL, on rst asserted mid-WAIT, abandon the in-flight op and ignore any later vpu_op_done until a new ISSUE.

Configuration
REQ-028 SHALL, when VPU_SEQ_TIMEOUT_EN is defined, count WAIT cycles and, if TIMEOUT_CYCLES elapse without vpu_op_done, set err_timeout (sticky until rst), pop the head without incrementing retire_cnt, and return to IDLE.
REQ-029 SHALL, when VPU_SEQ_TIMEOUT_EN is undefined, omit the timeout counter, tie err_timeout to 0, and remain in WAIT indefinitely.

Structure
REQ-030 SHALL place the FSM state enum, the command-entry struct (funct, vs1, vs2, vr, vl) and the field-width constants in a shared package vpu_seq_pkg.
REQ-031 SHALL implement the queue as sub-module vpu_seq_fifo (synchronous FIFO with push/pop/flush and count), instantiated once.

Verification
REQ-032 SHALL verify: push funct=0x01, vs1=1, vs2=2, vr=3, vl=4 at cycle 0 -> vpu_start_op=1 only at cycle 2 with those fields; op_done at cycle 6 -> retire_cnt=1, busy=0 at cycle 7.
REQ-033 SHALL verify: push 5 commands with QUEUE_DEPTH=4, VPU never completing -> in_ready=0 after 4 accepts; queue_count=4.
REQ-034 SHALL verify: queue 3 commands, flush during WAIT of the first -> queue_count=1; first completes on op_done; no further vpu_start_op.
REQ-035 SHALL verify: head vl=0 followed by vl=8 -> no start_op for the first, retire_cnt=1, the second issues the following cycle.
REQ-036 SHALL verify: with VPU_SEQ_TIMEOUT_EN, TIMEOUT_CYCLES=10 and no op_done -> err_timeout=1 ten cycles into WAIT; FSM back in IDLE; retire_cnt unchanged.
REQ-037 SHALL verify: rst asserted during WAIT followed by a stray op_done -> all outputs 0 and retire_cnt stays 0.

Source files
------------

// File: rtl/vpu_seq_pkg.sv
// rtl/vpu_seq_pkg.sv - shared types and field widths for the VPU issue sequencer
package vpu_seq_pkg;

    localparam int FUNCT_W  = 7;
    localparam int REG_W    = 5;
    localparam int VL_W     = 32;
    localparam int RETIRE_W = 16;
    localparam int TMO_W    = 16;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2
    } seq_state_e;

    typedef struct packed {
        logic [FUNCT_W-1:0] funct;
        logic [REG_W-1:0]   vs1;
        logic [REG_W-1:0]   vs2;
        logic [REG_W-1:0]   vr;
        logic [VL_W-1:0]    vl;
    } vpu_cmd_t;

endpackage

// File: rtl/vpu_seq_fifo.sv
// rtl/vpu_seq_fifo.sv - in-order command FIFO with push/pop/flush and occupancy count
module vpu_seq_fifo
    import vpu_seq_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic                     clk,
    input  logic                     rst,
    input  logic                     push_i,
    input  vpu_cmd_t                 push_data_i,
    input  logic                     pop_i,
    input  logic                     flush_i,
    input  logic                     flush_keep_i,
    output vpu_cmd_t                 head_o,
    output logic                     full_o,
    output logic                     empty_o,
    output logic [$clog2(DEPTH):0]   count_o
);

    localparam int AW = $clog2(DEPTH);
    localparam int CW = AW + 1;

    vpu_cmd_t        mem_q [DEPTH];
    logic [AW-1:0]   rd_q;
    logic [AW-1:0]   wr_q;
    logic [CW-1:0]   count_q;
    logic            push_ok;
    logic            pop_ok;

    assign full_o  = (count_q == CW'(DEPTH));
    assign empty_o = (count_q == '0);
    assign count_o = count_q;
    assign head_o  = mem_q[rd_q];

    assign push_ok = push_i && !full_o && !flush_i;
    assign pop_ok  = pop_i && !empty_o;

    always_ff @(posedge clk) begin
        if (push_ok) begin
            mem_q[wr_q] <= push_data_i;
        end
    end

    // Flush keeps the head slot when it holds the op currently in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            rd_q    <= '0;
            wr_q    <= '0;
            count_q <= '0;
        end else if (flush_i) begin
            if (flush_keep_i && !pop_ok) begin
                wr_q    <= rd_q + AW'(1);
                count_q <= CW'(1);
            end else begin
                rd_q    <= rd_q + AW'(pop_ok);
                wr_q    <= rd_q + AW'(pop_ok);
                count_q <= '0;
            end
        end else begin
            if (push_ok) begin
                wr_q <= wr_q + AW'(1);
            end
            if (pop_ok) begin
                rd_q <= rd_q + AW'(1);
            end
            case ({push_ok, pop_ok})
                2'b10:   count_q <= count_q + CW'(1);
                2'b01:   count_q <= count_q - CW'(1);
                default: count_q <= count_q;
            endcase
        end
    end

endmodule

// File: rtl/vpu_issue_sequencer.sv
// rtl/vpu_issue_sequencer.sv - queues vector commands and issues them one at a time to the VPU
// Optional WAIT timeout enabled by defining VPU_SEQ_TIMEOUT_EN.
module vpu_issue_sequencer
    import vpu_seq_pkg::*;
#(
    parameter int QUEUE_DEPTH    = 4,
    parameter int TIMEOUT_CYCLES = 255
) (
    input  logic                          clk,
    input  logic                          rst,
    input  logic                          in_valid,
    output logic                          in_ready,
    input  logic [FUNCT_W-1:0]            in_funct,
    input  logic [REG_W-1:0]              in_vs1,
    input  logic [REG_W-1:0]              in_vs2,
    input  logic [REG_W-1:0]              in_vr,
    input  logic [VL_W-1:0]               in_vl,
    output logic                          vpu_enable,
    output logic                          vpu_start_op,
    output logic [FUNCT_W-1:0]            vpu_funct,
    output logic [REG_W-1:0]              vpu_vs1,
    output logic [REG_W-1:0]              vpu_vs2,
    output logic [REG_W-1:0]              vpu_vr,
    output logic [VL_W-1:0]               vpu_vl,
    input  logic                          vpu_op_done,
    input  logic                          flush,
    output logic                          busy,
    output logic [$clog2(QUEUE_DEPTH):0]  queue_count,
    output logic [RETIRE_W-1:0]           retire_cnt,
    output logic                          err_timeout
);

    if (QUEUE_DEPTH < 2 || QUEUE_DEPTH > 16 || (QUEUE_DEPTH & (QUEUE_DEPTH - 1)) != 0) begin : g_bad_depth
        $error("QUEUE_DEPTH must be a power of two in 2..16");
    end
    if (TIMEOUT_CYCLES < 1 || TIMEOUT_CYCLES > 65535) begin : g_bad_tmo
        $error("TIMEOUT_CYCLES must be in 1..65535");
    end

    seq_state_e           state_q;
    logic                 start_q;
    logic                 enable_q;
    vpu_cmd_t             cmd_q;
    logic [RETIRE_W-1:0]  retire_q;

    vpu_cmd_t             head;
    vpu_cmd_t             in_cmd;
    logic                 fifo_full;
    logic                 fifo_empty;
    logic                 push;
    logic                 pop;
    logic                 skip_head;
    logic                 tmo_hit;

    assign in_cmd    = '{funct: in_funct, vs1: in_vs1, vs2: in_vs2, vr: in_vr, vl: in_vl};
    assign in_ready  = !fifo_full && !flush;
    assign push      = in_valid && in_ready;
    assign skip_head = (state_q == S_IDLE) && !flush && !fifo_empty && (head.vl == '0);
    assign pop       = skip_head || ((state_q == S_WAIT) && vpu_op_done) || tmo_hit;

`ifdef VPU_SEQ_TIMEOUT_EN
    logic [TMO_W-1:0] tmo_q;
    logic             err_q;

    assign tmo_hit     = (state_q == S_WAIT) && !vpu_op_done && (tmo_q == TMO_W'(TIMEOUT_CYCLES - 1));
    assign err_timeout = err_q;
`else
    assign tmo_hit     = 1'b0;
    assign err_timeout = 1'b0;
`endif

    vpu_seq_fifo #(
        .DEPTH (QUEUE_DEPTH)
    ) u_fifo (
        .clk          (clk),
        .rst          (rst),
        .push_i       (push),
        .push_data_i  (in_cmd),
        .pop_i        (pop),
        .flush_i      (flush),
        .flush_keep_i (state_q != S_IDLE),
        .head_o       (head),
        .full_o       (fifo_full),
        .empty_o      (fifo_empty),
        .count_o      (queue_count)
    );

    // The head stays queued while in flight, so occupancy alone tells us whether work remains.
    assign busy         = (queue_count != '0);
    assign vpu_enable   = enable_q;
    assign vpu_start_op = start_q;
    assign vpu_funct    = cmd_q.funct;
    assign vpu_vs1      = cmd_q.vs1;
    assign vpu_vs2      = cmd_q.vs2;
    assign vpu_vr       = cmd_q.vr;
    assign vpu_vl       = cmd_q.vl;
    assign retire_cnt   = retire_q;

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q  <= S_IDLE;
            start_q  <= 1'b0;
            enable_q <= 1'b0;
            cmd_q    <= '0;
            retire_q <= '0;
`ifdef VPU_SEQ_TIMEOUT_EN
            tmo_q    <= '0;
            err_q    <= 1'b0;
`endif
        end else begin
            start_q <= 1'b0;
            case (state_q)
                S_IDLE: begin
                    if (skip_head) begin
                        retire_q <= retire_q + RETIRE_W'(1);
                    end else if (!flush && !fifo_empty) begin
                        state_q  <= S_ISSUE;
                        start_q  <= 1'b1;
                        enable_q <= 1'b1;
                        cmd_q    <= head;
                    end
                end
                S_ISSUE: begin
                    state_q <= S_WAIT;
`ifdef VPU_SEQ_TIMEOUT_EN
                    tmo_q   <= '0;
`endif
                end
                S_WAIT: begin
                    if (vpu_op_done) begin
                        state_q  <= S_IDLE;
                        enable_q <= 1'b0;
                        retire_q <= retire_q + RETIRE_W'(1);
                    end
`ifdef VPU_SEQ_TIMEOUT_EN
                    else if (tmo_hit) begin
                        state_q  <= S_IDLE;
                        enable_q <= 1'b0;
                        err_q    <= 1'b1;
                    end else begin
                        tmo_q <= tmo_q + TMO_W'(1);
                    end
`endif
                end
                default: state_q <= S_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_vpu_issue_sequencer.sv
// tb/tb_vpu_issue_sequencer.sv - directed vector bench for vpu_issue_sequencer
module tb_vpu_issue_sequencer;

    localparam int QD  = 4;
    localparam int TMO = 10;

    logic        clk = 1'b0;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [6:0]  in_funct;
    logic [4:0]  in_vs1, in_vs2, in_vr;
    logic [31:0] in_vl;
    logic        vpu_enable, vpu_start_op;
    logic [6:0]  vpu_funct;
    logic [4:0]  vpu_vs1, vpu_vs2, vpu_vr;
    logic [31:0] vpu_vl;
    logic        vpu_op_done;
    logic        flush;
    logic        busy;
    logic [2:0]  queue_count;
    logic [15:0] retire_cnt;
    logic        err_timeout;

    vpu_issue_sequencer #(.QUEUE_DEPTH(QD), .TIMEOUT_CYCLES(TMO)) dut (
        .clk(clk), .rst(rst),
        .in_valid(in_valid), .in_ready(in_ready),
        .in_funct(in_funct), .in_vs1(in_vs1), .in_vs2(in_vs2), .in_vr(in_vr), .in_vl(in_vl),
        .vpu_enable(vpu_enable), .vpu_start_op(vpu_start_op),
        .vpu_funct(vpu_funct), .vpu_vs1(vpu_vs1), .vpu_vs2(vpu_vs2), .vpu_vr(vpu_vr), .vpu_vl(vpu_vl),
        .vpu_op_done(vpu_op_done), .flush(flush), .busy(busy), .queue_count(queue_count),
        .retire_cnt(retire_cnt), .err_timeout(err_timeout)
    );

    always #5 clk = ~clk;

    typedef struct {
        logic        v;
        logic [6:0]  f;
        logic [4:0]  s1, s2, r;
        logic [31:0] vl;
        logic        done;
        logic        fl;
        logic        e_start, e_en, e_busy, e_rdy;
        int          e_cnt;
        int          e_ret;
        logic [53:0] e_fields;
    } vec_t;

    vec_t vt[$];
    int total = 0;
    int bad   = 0;
    int cyc   = 0;

    function automatic logic [53:0] fld(input logic [6:0] f, input logic [4:0] s1, input logic [4:0] s2,
                                        input logic [4:0] r, input logic [31:0] vl);
        return {f, s1, s2, r, vl};
    endfunction

    function automatic vec_t mk(input logic v, input logic [6:0] f, input logic [4:0] s1, input logic [4:0] s2,
                                input logic [4:0] r, input logic [31:0] vl, input logic done, input logic fl,
                                input logic e_start, input logic e_en, input logic e_busy, input logic e_rdy,
                                input int e_cnt, input int e_ret, input logic [53:0] e_fields);
        vec_t x;
        x.v = v; x.f = f; x.s1 = s1; x.s2 = s2; x.r = r; x.vl = vl; x.done = done; x.fl = fl;
        x.e_start = e_start; x.e_en = e_en; x.e_busy = e_busy; x.e_rdy = e_rdy;
        x.e_cnt = e_cnt; x.e_ret = e_ret; x.e_fields = e_fields;
        return x;
    endfunction

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s cycle=%0d got=%0h expected=%0h", name, cyc, act, exp);
        end
    endtask

    task automatic step();
        @(posedge clk);
        #1;
        cyc++;
    endtask

    task automatic drive(input logic v, input logic [6:0] f, input logic [4:0] s1, input logic [4:0] s2,
                         input logic [4:0] r, input logic [31:0] vl);
        in_valid = v; in_funct = f; in_vs1 = s1; in_vs2 = s2; in_vr = r; in_vl = vl;
    endtask

    task automatic do_reset(input logic check);
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        vpu_op_done = 1'b0;
        flush = 1'b0;
        rst = 1'b1;
        step();
        step();
        rst = 1'b0;
        cyc = 0;
        if (check) begin
            chk("rst_start", vpu_start_op, 1'b0);
            chk("rst_enable", vpu_enable, 1'b0);
            chk("rst_busy", busy, 1'b0);
            chk("rst_count", queue_count, 0);
            chk("rst_retire", retire_cnt, 0);
            chk("rst_err", err_timeout, 1'b0);
            chk("rst_fields", {vpu_funct, vpu_vs1, vpu_vs2, vpu_vr, vpu_vl}, 0);
            chk("rst_in_ready", in_ready, 1'b1);
        end
    endtask

    initial begin
        logic [53:0] c1;
        logic [53:0] c3;
        logic [53:0] z;
        int acc;
        int starts;

        c1 = fld(7'h01, 5'd1, 5'd2, 5'd3, 32'd4);
        c3 = fld(7'h03, 5'd4, 5'd5, 5'd6, 32'd8);
        z  = '0;
        //             v  f  s1 s2 r  vl dn fl  st en bz rd cnt ret fields
        vt.push_back(mk(1, 1, 1, 2, 3, 4, 0, 0,  0, 0, 0, 1, 0, 0, z));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1, 0, z));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 1, 1, 0, c1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 1, 1, 0, c1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 1, 1, 0, c1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 1, 1, 0, c1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 1, 1, 1, 0, c1));
        vt.push_back(mk(1, 2, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 1, c1));
        vt.push_back(mk(1, 3, 4, 5, 6, 8, 0, 0,  0, 0, 1, 1, 1, 1, c1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 1, 1, 2, c1));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  1, 1, 1, 1, 1, 2, c3));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 1, 1, 1, 1, 2, c3));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 1, 0,  0, 1, 1, 1, 1, 2, c3));
        vt.push_back(mk(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 1, 0, 3, c3));

        do_reset(1'b1);

        foreach (vt[i]) begin
            drive(vt[i].v, vt[i].f, vt[i].s1, vt[i].s2, vt[i].r, vt[i].vl);
            vpu_op_done = vt[i].done;
            flush = vt[i].fl;
            #1;
            chk("vec_start", vpu_start_op, vt[i].e_start);
            chk("vec_enable", vpu_enable, vt[i].e_en);
            chk("vec_busy", busy, vt[i].e_busy);
            chk("vec_in_ready", in_ready, vt[i].e_rdy);
            chk("vec_count", queue_count, vt[i].e_cnt);
            chk("vec_retire", retire_cnt, vt[i].e_ret);
            chk("vec_fields", {vpu_funct, vpu_vs1, vpu_vs2, vpu_vr, vpu_vl}, vt[i].e_fields);
            chk("vec_err", err_timeout, 1'b0);
            step();
        end
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        vpu_op_done = 1'b0;

        // Fill past capacity while the VPU never answers.
        do_reset(1'b0);
        acc = 0;
        for (int i = 0; i < 6; i++) begin
            drive(1'b1, 7'(i + 16), 5'd1, 5'd1, 5'd1, 32'd1);
            #1;
            if (in_ready) acc++;
            step();
        end
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        chk("full_accepts", acc, 4);
        chk("full_in_ready", in_ready, 1'b0);
        chk("full_count", queue_count, 4);
        chk("full_enable", vpu_enable, 1'b1);

        // Reset in WAIT, then a stray op_done must not retire anything.
        rst = 1'b1;
        step();
        rst = 1'b0;
        vpu_op_done = 1'b1;
        step();
        vpu_op_done = 1'b0;
        step();
        chk("rstw_start", vpu_start_op, 1'b0);
        chk("rstw_enable", vpu_enable, 1'b0);
        chk("rstw_busy", busy, 1'b0);
        chk("rstw_count", queue_count, 0);
        chk("rstw_retire", retire_cnt, 0);
        chk("rstw_err", err_timeout, 1'b0);
        chk("rstw_fields", {vpu_funct, vpu_vs1, vpu_vs2, vpu_vr, vpu_vl}, 0);
        chk("rstw_in_ready", in_ready, 1'b1);

        // Flush during WAIT keeps only the in-flight op; op_done in ISSUE is ignored.
        do_reset(1'b0);
        drive(1'b1, 7'h11, 5'd1, 5'd1, 5'd1, 32'd2);
        step();
        drive(1'b1, 7'h12, 5'd2, 5'd2, 5'd2, 32'd2);
        step();
        drive(1'b1, 7'h13, 5'd3, 5'd3, 5'd3, 32'd2);
        vpu_op_done = 1'b1;
        chk("fl_issue_start", vpu_start_op, 1'b1);
        step();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        vpu_op_done = 1'b0;
        chk("fl_issue_done_ignored", {vpu_enable, retire_cnt}, {1'b1, 16'd0});
        chk("fl_count3", queue_count, 3);
        step();
        drive(1'b1, 7'h14, 5'd4, 5'd4, 5'd4, 32'd2);
        flush = 1'b1;
        #1;
        chk("fl_in_ready_low", in_ready, 1'b0);
        step();
        flush = 1'b0;
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        chk("fl_count1", queue_count, 1);
        chk("fl_enable", vpu_enable, 1'b1);
        chk("fl_funct", vpu_funct, 7'h11);
        vpu_op_done = 1'b1;
        step();
        vpu_op_done = 1'b0;
        chk("fl_done_count", queue_count, 0);
        chk("fl_done_retire", retire_cnt, 1);
        chk("fl_done_busy", busy, 1'b0);
        starts = 0;
        for (int i = 0; i < 6; i++) begin
            if (vpu_start_op) starts++;
            step();
        end
        chk("fl_no_more_starts", starts, 0);

        // WAIT with no op_done: timeout fires after TMO WAIT cycles, or waits forever without it.
        do_reset(1'b0);
        drive(1'b1, 7'h21, 5'd7, 5'd8, 5'd9, 32'd5);
        step();
        drive(1'b0, 7'd0, 5'd0, 5'd0, 5'd0, 32'd0);
        while (cyc < 12) step();
        chk("tmo_before_err", err_timeout, 1'b0);
        chk("tmo_before_en", vpu_enable, 1'b1);
        step();
`ifdef VPU_SEQ_TIMEOUT_EN
        chk("tmo_err", err_timeout, 1'b1);
        chk("tmo_idle_enable", vpu_enable, 1'b0);
        chk("tmo_count", queue_count, 0);
        chk("tmo_retire", retire_cnt, 0);
        step();
        step();
        chk("tmo_sticky", {err_timeout, vpu_start_op}, {1'b1, 1'b0});
`else
        chk("notmo_err", err_timeout, 1'b0);
        chk("notmo_enable", vpu_enable, 1'b1);
        chk("notmo_count", queue_count, 1);
        for (int i = 0; i < 20; i++) step();
        chk("notmo_still_wait", {vpu_enable, err_timeout, retire_cnt}, {1'b1, 1'b0, 16'd0});
`endif

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
